// File: rtl/operand_gen.sv
// operand_gen: issues incrementing (a, b) operand pairs over valid/ready.
// Each accepted pair produces an expected-sum write one cycle later.
module operand_gen #(
  parameter int unsigned WIDTH   = 5,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned NUM_TXN = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  a_init,
  input  logic [WIDTH-1:0]  b_init,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_a,
  output logic [WIDTH-1:0]  out_b,
  output logic              exp_we,
  output logic [ADDR_W-1:0] exp_addr,
  output logic [WIDTH:0]    exp_data,
  output logic [ADDR_W:0]   txn_count,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // txn_count value at which the next handshake is the final one of the run
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_TXN - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              hs;

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign hs        = out_valid && out_ready;

  // FSM, operand sequencing and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_a     <= '0;
      out_b     <= '0;
      ptr       <= '0;
      txn_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            out_a     <= a_init;
            out_b     <= b_init;
            ptr       <= '0;
            txn_count <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            out_a     <= out_a + 1'b1;
            out_b     <= out_b + 1'b1;
            ptr       <= ptr + 1'b1;
            txn_count <= txn_count + 1'b1;
            if (txn_count == LAST_IDX) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Expected-memory write port: one-cycle-delayed record of each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_we   <= 1'b0;
      exp_addr <= '0;
      exp_data <= '0;
    end else begin
      exp_we <= hs;
      if (hs) begin
        exp_addr <= ptr;
        exp_data <= {1'b0, out_a} + {1'b0, out_b};
      end
    end
  end

endmodule

// File: tb/tb_operand_gen.sv
// tb_operand_gen: directed-vector bench for operand_gen.
// u_dut runs NUM_TXN=4 scenarios; u_wrap runs the NUM_TXN=3 wrap scenario.
module tb_operand_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u_dut signals
  logic       start = 1'b0, out_ready = 1'b0;
  logic [4:0] a_init = '0, b_init = '0;
  logic       out_valid, exp_we, busy, done;
  logic [4:0] out_a, out_b;
  logic [7:0] exp_addr;
  logic [5:0] exp_data;
  logic [8:0] txn_count;

  // u_wrap signals
  logic       start_w = 1'b0, out_ready_w = 1'b0;
  logic [4:0] a_init_w = '0, b_init_w = '0;
  logic       out_valid_w, exp_we_w, busy_w, done_w;
  logic [4:0] out_a_w, out_b_w;
  logic [7:0] exp_addr_w;
  logic [5:0] exp_data_w;
  logic [8:0] txn_count_w;

  int total = 0;
  int bad   = 0;

  operand_gen #(.WIDTH(5), .ADDR_W(8), .NUM_TXN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_init(a_init), .b_init(b_init),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .txn_count(txn_count), .busy(busy), .done(done)
  );

  operand_gen #(.WIDTH(5), .ADDR_W(8), .NUM_TXN(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .start(start_w), .a_init(a_init_w), .b_init(b_init_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_a(out_a_w), .out_b(out_b_w),
    .exp_we(exp_we_w), .exp_addr(exp_addr_w), .exp_data(exp_data_w),
    .txn_count(txn_count_w), .busy(busy_w), .done(done_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // hand-computed vectors: basic run a_init=1, b_init=2
  int pa [4] = '{1, 2, 3, 4};
  int pb [4] = '{2, 3, 4, 5};
  int sd [4] = '{3, 5, 7, 9};
  // wrap run a_init=31, b_init=30
  int wa [3] = '{31, 0, 1};
  int wb [3] = '{30, 31, 0};
  int wd [3] = '{61, 31, 1};

  initial begin
    // reset state
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_a", out_a, 0);
    chk("rst_b", out_b, 0);
    chk("rst_we", exp_we, 0);
    chk("rst_addr", exp_addr, 0);
    chk("rst_data", exp_data, 0);
    chk("rst_cnt", txn_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    step();
    rst_n = 1'b1;
    step();

    // basic run
    start = 1'b1; a_init = 5'd1; b_init = 5'd2; out_ready = 1'b1;
    step();
    start = 1'b0;
    chk("st_valid", out_valid, 1);
    chk("st_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk("basic_a", out_a, pa[i]);
      chk("basic_b", out_b, pb[i]);
      chk("basic_valid", out_valid, 1);
      step();
      chk("basic_we", exp_we, 1);
      chk("basic_addr", exp_addr, i);
      chk("basic_data", exp_data, sd[i]);
    end
    chk("basic_done", done, 1);
    chk("basic_valid_end", out_valid, 0);
    chk("basic_busy_end", busy, 0);
    chk("basic_cnt", txn_count, 4);
    step();
    chk("idle_we", exp_we, 0);
    chk("hold_addr", exp_addr, 3);
    chk("hold_data", exp_data, 9);
    chk("hold_done", done, 1);
    chk("hold_a", out_a, 5);
    chk("hold_b", out_b, 6);
    chk("hold_cnt", txn_count, 4);

    // backpressure, restart from DONE, start ignored mid-run
    start = 1'b1; a_init = 5'd1; b_init = 5'd2; out_ready = 1'b0;
    step();
    start = 1'b0;
    chk("bp_cnt_clr", txn_count, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      step();
      chk("bp_a", out_a, 1);
      chk("bp_b", out_b, 2);
      chk("bp_we", exp_we, 0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_run_a", out_a, pa[i]);
      chk("bp_run_b", out_b, pb[i]);
      if (i == 2) begin
        start = 1'b1; a_init = 5'd9; b_init = 5'd9;
      end
      step();
      start = 1'b0;
      chk("bp_run_we", exp_we, 1);
      chk("bp_run_addr", exp_addr, i);
      chk("bp_run_data", exp_data, sd[i]);
    end
    chk("bp_done", done, 1);
    chk("bp_cnt", txn_count, 4);

    // restart from DONE with (9,9)
    start = 1'b1; a_init = 5'd9; b_init = 5'd9;
    step();
    start = 1'b0;
    chk("rs_a", out_a, 9);
    chk("rs_b", out_b, 9);
    chk("rs_done", done, 0);
    step();
    chk("rs_addr", exp_addr, 0);
    chk("rs_data", exp_data, 18);
    step();
    chk("rs_we2", exp_we, 1);
    chk("rs_addr2", exp_addr, 1);
    chk("rs_data2", exp_data, 20);

    // asynchronous reset after 2 handshakes, with a write pending
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_we", exp_we, 0);
    chk("ar_addr", exp_addr, 0);
    chk("ar_data", exp_data, 0);
    chk("ar_a", out_a, 0);
    chk("ar_b", out_b, 0);
    chk("ar_cnt", txn_count, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    #1;
    rst_n = 1'b1;
    step();
    chk("ar_idle_we", exp_we, 0);
    chk("ar_idle_valid", out_valid, 0);
    start = 1'b1; a_init = 5'd1; b_init = 5'd2;
    step();
    start = 1'b0;
    step();
    chk("ar_rs_we", exp_we, 1);
    chk("ar_rs_addr", exp_addr, 0);
    chk("ar_rs_data", exp_data, 3);

    // wrap run on u_wrap
    start_w = 1'b1; a_init_w = 5'd31; b_init_w = 5'd30; out_ready_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wr_a", out_a_w, wa[i]);
      chk("wr_b", out_b_w, wb[i]);
      step();
      chk("wr_we", exp_we_w, 1);
      chk("wr_addr", exp_addr_w, i);
      chk("wr_data", exp_data_w, wd[i]);
    end
    chk("wr_done", done_w, 1);
    chk("wr_cnt", txn_count_w, 3);
    chk("wr_valid_end", out_valid_w, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
